// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite master arbiter: FSM states,
// response codes and the reset value of the protection field.
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_DATA,
    S_RSP
  } state_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  localparam logic [2:0]  PROT_DEFAULT = 3'b000;
  localparam logic [15:0] ERR_MAX      = 16'hFFFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Ports: req_i requests, ptr_i start index, gnt_o one-hot, idx_o index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the requester
  // closest to ptr_i is the last (winning) assignment.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (req_i[cand]) idx_o = cand;
    end
    if (req_i[idx_o]) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/axi4_lite_master_arbiter.sv
// Round-robin sharing of one AXI4-Lite master among NUM_REQ requesters.
// Ports: cmd_* requester commands, rsp_* completions, AXI4-Lite master, busy/err_count.
module axi4_lite_master_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [NUM_REQ-1:0]         cmd_valid,
  output logic [NUM_REQ-1:0]         cmd_ready,
  input  logic [NUM_REQ-1:0]         cmd_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  cmd_addr,
  input  logic [NUM_REQ*3-1:0]       cmd_prot,
  input  logic [NUM_REQ*DATA_W-1:0]  cmd_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] cmd_wstrb,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [1:0]                 rsp_resp,
  output logic                       busy,
  output logic [15:0]                err_count,
  output logic [ADDR_W-1:0]          awaddr,
  output logic [2:0]                 awprot,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [DATA_W-1:0]          wdata,
  output logic [DATA_W/8-1:0]        wstrb,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic [1:0]                 bresp,
  input  logic                       bvalid,
  output logic                       bready,
  output logic [ADDR_W-1:0]          araddr,
  output logic [2:0]                 arprot,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [DATA_W-1:0]          rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rvalid,
  output logic                       rready
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = DATA_W / 8;

  state_t              state_q;
  logic [IW-1:0]       ptr_q;
  logic [IW-1:0]       gidx_q;
  logic [IW-1:0]       win_idx;
  logic [NUM_REQ-1:0]  win_gnt;
  logic [NUM_REQ-1:0]  gidx_oh;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [ADDR_W-1:0]   win_addr;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic [2:0]          win_prot;
  logic [2:0]          awprot_q;
  logic [2:0]          arprot_q;
  logic [DATA_W-1:0]   win_wdata;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [SW-1:0]       win_wstrb;
  logic [SW-1:0]       wstrb_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                arvalid_q;
  logic                rready_q;
  resp_t               rsp_resp_q;
  logic [15:0]         err_cnt_q;
  logic [15:0]         err_cnt_d;
  logic [IW-1:0]       ptr_d;
  logic                aw_done;
  logic                w_done;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req_i (cmd_valid),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx)
  );

  assign win_addr  = cmd_addr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_prot  = cmd_prot[int'(win_idx)*3 +: 3];
  assign win_wdata = cmd_wdata[int'(win_idx)*DATA_W +: DATA_W];
  assign win_wstrb = cmd_wstrb[int'(win_idx)*SW +: SW];

  // A channel counts as done if it already handshook or does so now.
  assign aw_done = !awvalid_q || awready;
  assign w_done  = !wvalid_q || wready;

  always_comb begin
    gidx_oh = '0;
    gidx_oh[gidx_q] = 1'b1;
  end

  assign err_cnt_d = (rsp_resp_q != RESP_OKAY && err_cnt_q != ERR_MAX)
                   ? err_cnt_q + 16'd1 : err_cnt_q;

  assign ptr_d = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      awaddr_q    <= '0;
      awprot_q    <= PROT_DEFAULT;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      araddr_q    <= '0;
      arprot_q    <= PROT_DEFAULT;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
      err_cnt_q   <= '0;
    end else begin
      rsp_valid_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (|cmd_valid) begin
            gidx_q <= win_idx;
            if (cmd_write[win_idx]) begin
              awaddr_q  <= win_addr;
              awprot_q  <= win_prot;
              wdata_q   <= win_wdata;
              wstrb_q   <= win_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WR_REQ;
            end else begin
              araddr_q  <= win_addr;
              arprot_q  <= win_prot;
              arvalid_q <= 1'b1;
              state_q   <= S_RD_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= resp_t'(bresp);
            rsp_rdata_q <= '0;
            rsp_valid_q <= gidx_oh;
            state_q     <= S_RSP;
          end
        end
        S_RD_REQ: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            rready_q    <= 1'b0;
            rsp_resp_q  <= resp_t'(rresp);
            rsp_rdata_q <= rdata;
            rsp_valid_q <= gidx_oh;
            state_q     <= S_RSP;
          end
        end
        S_RSP: begin
          err_cnt_q <= err_cnt_d;
          ptr_q     <= ptr_d;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Grants are offered only while idle and never during reset.
  assign cmd_ready = (state_q == S_IDLE && !areset) ? win_gnt : '0;
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign err_count = err_cnt_q;
  assign awaddr    = awaddr_q;
  assign awprot    = awprot_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;
  assign araddr    = araddr_q;
  assign arprot    = arprot_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// Self-checking bench: transaction-level model of arbitration,
// responses, latency and error counting against a delay-configurable slave.
module tb_axi4_lite_master_arbiter;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            aclk = 1'b0;
  logic            areset;
  logic [NR-1:0]   cmd_valid, cmd_ready, cmd_write, rsp_valid;
  logic [NR*AW-1:0] cmd_addr;
  logic [NR*3-1:0] cmd_prot;
  logic [NR*DW-1:0] cmd_wdata;
  logic [NR*SW-1:0] cmd_wstrb;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic            busy;
  logic [15:0]     err_count;
  logic [AW-1:0]   awaddr, araddr;
  logic [2:0]      awprot, arprot;
  logic            awvalid, awready, wvalid, wready;
  logic [DW-1:0]   wdata, rdata;
  logic [SW-1:0]   wstrb;
  logic [1:0]      bresp, rresp;
  logic            bvalid, bready, arvalid, arready;
  logic            rvalid, rready;

  always #5 aclk = ~aclk;

  axi4_lite_master_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .aclk (aclk), .areset (areset),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
    .cmd_write (cmd_write), .cmd_addr (cmd_addr),
    .cmd_prot (cmd_prot), .cmd_wdata (cmd_wdata),
    .cmd_wstrb (cmd_wstrb),
    .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata),
    .rsp_resp (rsp_resp), .busy (busy),
    .err_count (err_count),
    .awaddr (awaddr), .awprot (awprot),
    .awvalid (awvalid), .awready (awready),
    .wdata (wdata), .wstrb (wstrb),
    .wvalid (wvalid), .wready (wready),
    .bresp (bresp), .bvalid (bvalid), .bready (bready),
    .araddr (araddr), .arprot (arprot),
    .arvalid (arvalid), .arready (arready),
    .rdata (rdata), .rresp (rresp),
    .rvalid (rvalid), .rready (rready)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // slave configuration and the fields it must see on the bus
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  slv_resp = 2'b00;
  logic [DW-1:0] slv_rdata = '0;
  logic [AW-1:0] ex_addr = '0;
  logic [DW-1:0] ex_data = '0;
  logic [SW-1:0] ex_strb = '0;
  logic [2:0]    ex_prot = '0;
  int aw_cyc = 0, w_cyc = 0, ar_cyc = 0;
  int bad_aw = 0, bad_w = 0, bad_ar = 0, bad_order = 0;

  initial begin
    int aw_w, w_w, b_w, ar_w, r_w;
    aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    forever begin
      @(negedge aclk);
      if (awvalid) begin
        aw_cyc++;
        if (awaddr !== ex_addr || awprot !== ex_prot) bad_aw++;
        if (aw_w >= aw_dly) begin awready = 1; aw_w = 0; end
        else begin awready = 0; aw_w++; end
      end else begin awready = 0; aw_w = 0; end
      if (wvalid) begin
        w_cyc++;
        if (wdata !== ex_data || wstrb !== ex_strb) bad_w++;
        if (w_w >= w_dly) begin wready = 1; w_w = 0; end
        else begin wready = 0; w_w++; end
      end else begin wready = 0; w_w = 0; end
      if (bready) begin
        if (awvalid || wvalid) bad_order++;
        if (b_w >= b_dly) begin bvalid = 1; bresp = slv_resp; b_w = 0; end
        else begin bvalid = 0; b_w++; end
      end else begin bvalid = 0; b_w = 0; end
      if (arvalid) begin
        ar_cyc++;
        if (araddr !== ex_addr || arprot !== ex_prot) bad_ar++;
        if (ar_w >= ar_dly) begin arready = 1; ar_w = 0; end
        else begin arready = 0; ar_w++; end
      end else begin arready = 0; ar_w = 0; end
      if (rready) begin
        if (r_w >= r_dly) begin
          rvalid = 1; rdata = slv_rdata; rresp = slv_resp; r_w = 0;
        end else begin rvalid = 0; r_w++; end
      end else begin rvalid = 0; r_w = 0; end
    end
  end

  // pending requester commands and the model state
  bit            p_v [NR];
  bit            p_wr [NR];
  logic [AW-1:0] p_addr [NR];
  logic [DW-1:0] p_data [NR];
  logic [SW-1:0] p_strb [NR];
  logic [2:0]    p_prot [NR];
  int            m_ptr = 0;
  int            m_err = 0;
  int            grants[$];

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      cmd_valid[i] = p_v[i];
      cmd_write[i] = p_wr[i];
      cmd_addr[i*AW +: AW]  = p_addr[i];
      cmd_wdata[i*DW +: DW] = p_data[i];
      cmd_wstrb[i*SW +: SW] = p_strb[i];
      cmd_prot[i*3 +: 3]    = p_prot[i];
    end
  endtask

  task automatic new_cmd(input int i);
    p_v[i]    = 1;
    p_wr[i]   = 1'($urandom_range(0, 1));
    p_addr[i] = $urandom & 32'hFFFF_FFFC;
    p_data[i] = $urandom;
    p_strb[i] = SW'($urandom_range(1, 15));
    p_prot[i] = 3'($urandom_range(0, 7));
  endtask

  function automatic int model_winner();
    for (int k = 0; k < NR; k++)
      if (p_v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return 0;
  endfunction

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One transaction: grant, response, latency and error count.
  // Entered and left at a falling edge; leaves in the idle cycle.
  task automatic serve(input bit refill);
    int who, cyc, lat, explat;
    logic [DW-1:0] erd;
    logic [1:0] ers;
    who = model_winner();
    cyc = 0;
    #1;
    while (cmd_ready == '0 && cyc < 40) begin
      @(negedge aclk); #1; cyc++;
    end
    chk("grant", cmd_ready, onehot(who));
    ex_addr = p_addr[who]; ex_data = p_data[who];
    ex_strb = p_strb[who]; ex_prot = p_prot[who];
    explat = p_wr[who] ? 3 + max2(aw_dly, w_dly) + b_dly
                       : 3 + ar_dly + r_dly;
    erd = p_wr[who] ? '0 : slv_rdata;
    ers = slv_resp;
    grants.push_back(who);
    @(negedge aclk);
    if (refill) new_cmd(who);
    else p_v[who] = 0;
    drive();
    lat = 1;
    #1;
    while (rsp_valid == '0 && lat < 60) begin
      chk("ready_while_busy", cmd_ready, '0);
      chk("busy", busy, 1'b1);
      @(negedge aclk); #1; lat++;
    end
    chk("rsp_valid", rsp_valid, onehot(who));
    chk("latency", lat, explat);
    chk("rsp_rdata", rsp_rdata, erd);
    chk("rsp_resp", rsp_resp, ers);
    m_ptr = (who + 1) % NR;
    if (ers != 2'b00 && m_err < 65535) m_err++;
    @(negedge aclk); #1;
    chk("idle_busy", busy, 1'b0);
    chk("err_count", err_count, m_err);
    chk("slave_aw_fields", bad_aw, 0);
    chk("slave_w_fields", bad_w, 0);
    chk("slave_ar_fields", bad_ar, 0);
    chk("slave_b_order", bad_order, 0);
  endtask

  initial begin
    int base_aw, base_w, base_ar, cyc;
    areset = 1;
    for (int i = 0; i < NR; i++) begin
      p_v[i] = 0; p_wr[i] = 0; p_addr[i] = '0;
      p_data[i] = '0; p_strb[i] = '0; p_prot[i] = '0;
    end
    drive();
    repeat (3) @(negedge aclk);
    #1;
    chk("rst_cmd_ready", cmd_ready, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_count, 16'h0);
    chk("rst_awaddr", awaddr, '0);
    chk("rst_rdata", rsp_rdata, '0);
    @(negedge aclk);
    areset = 0;

    // single zero-wait write from requester 0
    p_v[0] = 1; p_wr[0] = 1; p_addr[0] = 32'h10;
    p_data[0] = 32'hDEADBEEF; p_strb[0] = 4'hF; p_prot[0] = 3'd0;
    drive();
    serve(0);

    // read from requester 1 with arready in the third cycle
    ar_dly = 2; slv_rdata = 32'h12345678; slv_resp = 2'b00;
    p_v[1] = 1; p_wr[1] = 0; p_addr[1] = 32'h20; p_prot[1] = 3'd2;
    drive();
    base_ar = ar_cyc;
    serve(0);
    chk("arvalid_cycles", ar_cyc - base_ar, 3);
    ar_dly = 0;

    // two requesters held continuously: strict alternation
    grants.delete();
    new_cmd(0); new_cmd(1);
    drive();
    for (int t = 0; t < 6; t++) serve(1);
    p_v[0] = 0; p_v[1] = 0;
    drive();
    for (int t = 0; t < 6; t++) chk("alternate", grants[t], t % 2);

    // W completes two cycles before AW
    aw_dly = 2; w_dly = 0;
    new_cmd(2); p_wr[2] = 1;
    drive();
    base_aw = aw_cyc; base_w = w_cyc;
    serve(0);
    chk("w_cycles", w_cyc - base_w, 1);
    chk("aw_cycles", aw_cyc - base_aw, 3);
    aw_dly = 0;

    // error responses
    slv_resp = 2'b10;
    new_cmd(0); p_wr[0] = 1;
    drive();
    serve(0);
    slv_resp = 2'b11; slv_rdata = 32'hCAFE0001;
    new_cmd(1); p_wr[1] = 0;
    drive();
    serve(0);
    chk("err_two", err_count, 16'd2);

    // randomized traffic
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NR; i++)
        if (!p_v[i] && $urandom_range(0, 2) != 0) new_cmd(i);
      if (!(p_v[0] || p_v[1] || p_v[2])) new_cmd($urandom_range(0, NR - 1));
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3);  ar_dly = $urandom_range(0, 3);
      r_dly = $urandom_range(0, 3);
      slv_resp = 2'($urandom_range(0, 3));
      slv_rdata = $urandom;
      drive();
      serve(0);
    end
    for (int i = 0; i < NR; i++) p_v[i] = 0;
    drive();
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;

    // saturation of the error counter
    force dut.err_cnt_q = 16'hFFFF;
    @(posedge aclk); #1;
    release dut.err_cnt_q;
    m_err = 65535;
    @(negedge aclk);
    slv_resp = 2'b10;
    new_cmd(0);
    drive();
    serve(0);
    chk("err_saturated", err_count, 16'hFFFF);

    // reset while waiting for the write response
    b_dly = 6; slv_resp = 2'b00;
    new_cmd(1); p_wr[1] = 1;
    drive();
    ex_addr = p_addr[1]; ex_data = p_data[1];
    ex_strb = p_strb[1]; ex_prot = p_prot[1];
    cyc = 0;
    #1;
    while (cmd_ready == '0 && cyc < 20) begin
      @(negedge aclk); #1; cyc++;
    end
    chk("rst_mid_grant", cmd_ready, onehot(1));
    @(negedge aclk);
    p_v[1] = 0;
    drive();
    cyc = 0;
    #1;
    while (!bready && cyc < 20) begin
      @(negedge aclk); #1; cyc++;
    end
    chk("rst_mid_in_wr_resp", bready, 1'b1);
    areset = 1;
    @(negedge aclk); #1;
    chk("rst_mid_valids", {awvalid, wvalid, arvalid, bready, rready}, '0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_rsp", rsp_valid, '0);
    chk("rst_mid_err", err_count, 16'h0);
    areset = 0;
    m_ptr = 0; m_err = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk); #1;
      chk("rst_mid_no_rsp", rsp_valid, '0);
    end
    b_dly = 0;
    grants.delete();
    new_cmd(0); new_cmd(1);
    drive();
    serve(0);
    serve(0);
    chk("post_rst_first", grants[0], 0);
    chk("post_rst_second", grants[1], 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
